// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS memory stage.
package mips_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    typedef enum logic {IDLE, WAIT} mem_state_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, stall, and MEM/WB outputs of the memory stage.
interface mem_stage_if;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_mem_size;
    logic        in_load_unsigned;
    logic        in_mem_to_reg;
    logic        in_reg_write;
    logic [4:0]  in_write_back_destination;
    logic [31:0] in_alu_result;
    logic [31:0] in_write_data;
    logic        stall;
    logic        out_valid;
    logic        out_mem_to_reg;
    logic        out_reg_write;
    logic [4:0]  out_write_back_destination;
    logic [31:0] out_address;
    logic [31:0] out_read_data;
    logic        out_misaligned;
    modport master (
        output in_valid, in_mem_read, in_mem_write, in_mem_size, in_load_unsigned,
               in_mem_to_reg, in_reg_write, in_write_back_destination, in_alu_result, in_write_data,
        input  stall, out_valid, out_mem_to_reg, out_reg_write, out_write_back_destination,
               out_address, out_read_data, out_misaligned
    );
    modport slave (
        input  in_valid, in_mem_read, in_mem_write, in_mem_size, in_load_unsigned,
               in_mem_to_reg, in_reg_write, in_write_back_destination, in_alu_result, in_write_data,
        output stall, out_valid, out_mem_to_reg, out_reg_write, out_write_back_destination,
               out_address, out_read_data, out_misaligned
    );
endinterface

// File: rtl/mem_stage_data_memory.sv
// data_memory: word array with byte-enabled synchronous write and combinational read.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];
    always_ff @(posedge clk)
        if (i_we)
            for (int b = 0; b < 4; b++)
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with multi-cycle data memory and MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 2
) (
    input logic       clk,
    input logic       rst_n,
    mem_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    mem_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]  w_lane, w_size;
    logic        w_mem_op, w_store, w_load, w_mis, w_stall_raw, w_we, w_take, w_uns;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_rword, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_lane   = bus.in_alu_result[1:0];
    assign w_size   = bus.in_mem_size;
    assign w_uns    = bus.in_load_unsigned;
    assign w_mem_op = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
    assign w_store  = w_mem_op & bus.in_mem_write;
    assign w_load   = w_mem_op & ~bus.in_mem_write;
    assign w_mis    = w_mem_op & (w_size == SIZE_BYTE ? 1'b0 : w_size == SIZE_HALF ? w_lane[0] : |w_lane);
    assign w_stall_raw = r_state == IDLE ? w_mem_op & (MEM_LATENCY > 1) : r_cnt > CW'(1);
    // Reset masks both stall and the write strobe so an aborted access never commits.
    assign bus.stall = rst_n & w_stall_raw;
    assign w_we      = rst_n & ~w_stall_raw & w_store & ~w_mis;
    assign w_take    = ~w_stall_raw & bus.in_valid;
    assign w_be    = w_size == SIZE_BYTE ? 4'b0001 << w_lane :
                     w_size == SIZE_HALF ? (w_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = w_size == SIZE_BYTE ? {4{bus.in_write_data[7:0]}} :
                     w_size == SIZE_HALF ? {2{bus.in_write_data[15:0]}} : bus.in_write_data;
    assign w_byte  = w_rword[8*w_lane +: 8];
    assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
    assign w_ext   = w_size == SIZE_BYTE ? {{24{~w_uns & w_byte[7]}}, w_byte} :
                     w_size == SIZE_HALF ? {{16{~w_uns & w_half[15]}}, w_half} : w_rword;
    data_memory #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (bus.in_alu_result[AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rword)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state                        <= IDLE;
            r_cnt                          <= '0;
            bus.out_valid                  <= 1'b0;
            bus.out_mem_to_reg             <= 1'b0;
            bus.out_reg_write              <= 1'b0;
            bus.out_write_back_destination <= '0;
            bus.out_address                <= '0;
            bus.out_read_data              <= '0;
            bus.out_misaligned             <= 1'b0;
        end else begin
            r_state <= r_state == IDLE & w_stall_raw ? WAIT :
                       r_state == WAIT & ~w_stall_raw ? IDLE : r_state;
            r_cnt   <= r_state == IDLE ? (w_stall_raw ? CW'(MEM_LATENCY - 1) : '0) : r_cnt - CW'(1);
            bus.out_valid                  <= w_take;
            bus.out_mem_to_reg             <= w_take & bus.in_mem_to_reg;
            bus.out_reg_write              <= w_take & bus.in_reg_write;
            bus.out_write_back_destination <= w_take ? bus.in_write_back_destination : '0;
            bus.out_address                <= w_take ? bus.in_alu_result : '0;
            bus.out_read_data              <= w_take & w_load & ~w_mis ? w_ext : '0;
            bus.out_misaligned             <= w_take & w_mis;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage at MEM_LATENCY 2 and 1.
module tb_mem_stage;
    import mips_pkg::*;
    typedef struct packed {
        logic rd, wr; logic [1:0] sz; logic uns, m2r, rw; logic [4:0] dest;
        logic [31:0] addr, wdata, exp_rd; logic exp_mis;
    } vec_t;
    typedef struct packed {
        logic [31:0] addr, rdata; logic [4:0] dest; logic rw, m2r, mis;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t q2[$];
    exp_t q1[$];
    mem_stage_if if2();
    mem_stage_if if1();
    mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_entry(input string tag, input exp_t e, input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [4:0] dest, input logic rw, input logic m2r, input logic mis);
        chk({tag, ".addr"}, addr, e.addr);
        chk({tag, ".rdata"}, rdata, e.rdata);
        chk({tag, ".dest"}, 32'(dest), 32'(e.dest));
        chk({tag, ".reg_write"}, 32'(rw), 32'(e.rw));
        chk({tag, ".mem_to_reg"}, 32'(m2r), 32'(e.m2r));
        chk({tag, ".misaligned"}, 32'(mis), 32'(e.mis));
    endtask

    always @(negedge clk) if (rst_n) begin
        if (if2.out_valid) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL d2.unexpected: valid entry addr %h with nothing expected", if2.out_address);
            end else cmp_entry("d2", q2.pop_front(), if2.out_address, if2.out_read_data,
                               if2.out_write_back_destination, if2.out_reg_write, if2.out_mem_to_reg, if2.out_misaligned);
        end else chk("d2.bubble_reg_write", 32'(if2.out_reg_write), 32'd0);
    end

    always @(negedge clk) if (rst_n) begin
        if (if1.out_valid) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL d1.unexpected: valid entry addr %h with nothing expected", if1.out_address);
            end else cmp_entry("d1", q1.pop_front(), if1.out_address, if1.out_read_data,
                               if1.out_write_back_destination, if1.out_reg_write, if1.out_mem_to_reg, if1.out_misaligned);
        end else chk("d1.bubble_reg_write", 32'(if1.out_reg_write), 32'd0);
    end

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                                input logic m2r, input logic rw, input logic [4:0] dest, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rd, input logic mis);
        return '{rd, wr, sz, uns, m2r, rw, dest, addr, wdata, exp_rd, mis};
    endfunction

    function automatic vec_t st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data, input logic mis);
        return mk(1'b0, 1'b1, sz, 1'b0, 1'b0, 1'b0, 5'd0, addr, data, 32'd0, mis);
    endfunction

    function automatic vec_t ld(input logic [1:0] sz, input logic uns, input logic [4:0] dest, input logic [31:0] addr,
                                input logic [31:0] exp_rd, input logic mis);
        return mk(1'b1, 1'b0, sz, uns, 1'b1, 1'b1, dest, addr, 32'h5A5A5A5A, exp_rd, mis);
    endfunction

    task automatic issue2(input vec_t v);
        int n = 0;
        exp_t e;
        e = '{v.addr, v.exp_rd, v.dest, v.rw, v.m2r, v.exp_mis};
        q2.push_back(e);
        if2.in_valid = 1'b1; if2.in_mem_read = v.rd; if2.in_mem_write = v.wr; if2.in_mem_size = v.sz;
        if2.in_load_unsigned = v.uns; if2.in_mem_to_reg = v.m2r; if2.in_reg_write = v.rw;
        if2.in_write_back_destination = v.dest; if2.in_alu_result = v.addr; if2.in_write_data = v.wdata;
        #1;
        while (if2.stall && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("d2.stall_cycles", n, (v.rd | v.wr) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        if2.in_valid = 1'b0; if2.in_mem_read = 1'b0; if2.in_mem_write = 1'b0;
    endtask

    task automatic issue1(input vec_t v);
        exp_t e;
        e = '{v.addr, v.exp_rd, v.dest, v.rw, v.m2r, v.exp_mis};
        q1.push_back(e);
        if1.in_valid = 1'b1; if1.in_mem_read = v.rd; if1.in_mem_write = v.wr; if1.in_mem_size = v.sz;
        if1.in_load_unsigned = v.uns; if1.in_mem_to_reg = v.m2r; if1.in_reg_write = v.rw;
        if1.in_write_back_destination = v.dest; if1.in_alu_result = v.addr; if1.in_write_data = v.wdata;
        #1;
        chk("d1.stall", 32'(if1.stall), 32'd0);
        @(posedge clk); #1;
        if1.in_valid = 1'b0; if1.in_mem_read = 1'b0; if1.in_mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        {if2.in_valid, if2.in_mem_read, if2.in_mem_write, if2.in_mem_size, if2.in_load_unsigned,
         if2.in_mem_to_reg, if2.in_reg_write, if2.in_write_back_destination, if2.in_alu_result, if2.in_write_data} = '0;
        {if1.in_valid, if1.in_mem_read, if1.in_mem_write, if1.in_mem_size, if1.in_load_unsigned,
         if1.in_mem_to_reg, if1.in_reg_write, if1.in_write_back_destination, if1.in_alu_result, if1.in_write_data} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.d2_outputs", {if2.stall, if2.out_valid, if2.out_reg_write, if2.out_mem_to_reg, if2.out_misaligned,
                                 27'(if2.out_write_back_destination)} | if2.out_address | if2.out_read_data, 32'd0);
        chk("reset.d1_outputs", {if1.stall, if1.out_valid, if1.out_reg_write, if1.out_mem_to_reg, if1.out_misaligned,
                                 27'(if1.out_write_back_destination)} | if1.out_address | if1.out_read_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue2(st(SIZE_WORD, 32'h10, 32'hDEADBEEF, 1'b0));
        issue2(ld(SIZE_WORD, 1'b0, 5'd5, 32'h10, 32'hDEADBEEF, 1'b0));
        issue2(st(SIZE_WORD, 32'h20, 32'h80FF7F01, 1'b0));
        issue2(ld(SIZE_BYTE, 1'b0, 5'd1, 32'h23, 32'hFFFFFF80, 1'b0));
        issue2(ld(SIZE_BYTE, 1'b1, 5'd2, 32'h21, 32'h0000007F, 1'b0));
        issue2(ld(SIZE_HALF, 1'b0, 5'd3, 32'h22, 32'hFFFF80FF, 1'b0));
        issue2(ld(SIZE_HALF, 1'b1, 5'd4, 32'h20, 32'h00007F01, 1'b0));
        issue2(st(SIZE_WORD, 32'h20, 32'h11223344, 1'b0));
        issue2(st(SIZE_BYTE, 32'h21, 32'h123456AA, 1'b0));
        issue2(ld(SIZE_WORD, 1'b0, 5'd6, 32'h20, 32'h1122AA44, 1'b0));
        issue2(st(SIZE_WORD, 32'h30, 32'h55667788, 1'b0));
        issue2(st(SIZE_WORD, 32'h32, 32'hCAFEBABE, 1'b1));
        issue2(ld(SIZE_WORD, 1'b0, 5'd7, 32'h30, 32'h55667788, 1'b0));
        issue2(ld(SIZE_HALF, 1'b0, 5'd8, 32'h31, 32'h0, 1'b1));
        issue2(st(SIZE_HALF, 32'h32, 32'hFFFFBEEF, 1'b0));
        issue2(ld(SIZE_WORD, 1'b0, 5'd9, 32'h30, 32'hBEEF7788, 1'b0));
        issue2(mk(1'b1, 1'b1, SIZE_WORD, 1'b0, 1'b1, 1'b1, 5'd7, 32'h40, 32'h0BADF00D, 32'h0, 1'b0));
        issue2(ld(2'b11, 1'b0, 5'd10, 32'h40, 32'h0BADF00D, 1'b0));
        issue2(ld(SIZE_BYTE, 1'b0, 5'd11, 32'h41, 32'hFFFFFFF0, 1'b0));
        issue2(ld(SIZE_WORD, 1'b0, 5'd3, 32'h42, 32'h0, 1'b1));
        issue2(mk(1'b0, 1'b0, SIZE_WORD, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1234, 32'h0, 32'h0, 1'b0));
        // strobes without in_valid must neither stall nor write
        if2.in_mem_read = 1'b1; if2.in_mem_write = 1'b1; if2.in_alu_result = 32'h40; if2.in_write_data = 32'hFFFFFFFF;
        #1;
        chk("d2.invalid_stall", 32'(if2.stall), 32'd0);
        @(posedge clk); #1;
        issue2(ld(SIZE_WORD, 1'b0, 5'd12, 32'h40, 32'h0BADF00D, 1'b0));
        // reset in WAIT aborts the store
        if2.in_valid = 1'b1; if2.in_mem_read = 1'b0; if2.in_mem_write = 1'b1; if2.in_mem_size = SIZE_WORD;
        if2.in_alu_result = 32'h40; if2.in_write_data = 32'h99999999;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("d2.reset_stall", 32'(if2.stall), 32'd0);
        chk("d2.reset_valid", 32'(if2.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("d2.reset_stall_edge", 32'(if2.stall), 32'd0);
        if2.in_valid = 1'b0; if2.in_mem_write = 1'b0;
        rst_n = 1'b1;
        #1;
        issue2(ld(SIZE_WORD, 1'b0, 5'd13, 32'h40, 32'h0BADF00D, 1'b0));
        issue1(mk(1'b0, 1'b0, SIZE_WORD, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1234, 32'h0, 32'h0, 1'b0));
        issue1(mk(1'b0, 1'b0, SIZE_WORD, 1'b0, 1'b0, 1'b1, 5'd10, 32'hABCD, 32'h0, 32'h0, 1'b0));
        issue1(st(SIZE_WORD, 32'h400, 32'h13579BDF, 1'b0));
        issue1(ld(SIZE_WORD, 1'b0, 5'd14, 32'h000, 32'h13579BDF, 1'b0));
        issue1(ld(SIZE_BYTE, 1'b1, 5'd15, 32'h403, 32'h00000013, 1'b0));
        issue1(ld(SIZE_HALF, 1'b0, 5'd16, 32'h001, 32'h0, 1'b1));
        repeat (3) @(posedge clk);
        #1;
        chk("d2.drain", q2.size(), 32'd0);
        chk("d1.drain", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
